// File: rtl/btn_debounce_pulse_pkg.sv
// Shared definitions for the push-button conditioner: debounce FSM state encoding,
// board button indices and the counter sizing helper.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    HELD         = 2'd2,
    WAIT_RELEASE = 2'd3
  } btn_state_e;

  localparam int unsigned BTN_C = 32'd0;
  localparam int unsigned BTN_D = 32'd1;
  localparam int unsigned BTN_U = 32'd2;
  localparam int unsigned BTN_R = 32'd3;
  localparam int unsigned BTN_L = 32'd4;

  // Largest of three timing constants; one counter is shared by debounce and repeat timing.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/btn_debounce_pulse_if.sv
// Button bundle between the board pins and the game core: raw levels in,
// debounced level, press pulse and repeat pulse out.
interface btn_debounce_pulse_if #(
  parameter int unsigned N_BTN = 32'd5
) ();

  logic [N_BTN-1:0] Btn_In;
  logic [N_BTN-1:0] Btn_Level;
  logic [N_BTN-1:0] Btn_Pulse;
  logic [N_BTN-1:0] Btn_Repeat;

  modport master (
    output Btn_In,
    input  Btn_Level,
    input  Btn_Pulse,
    input  Btn_Repeat
  );

  modport slave (
    input  Btn_In,
    output Btn_Level,
    output Btn_Pulse,
    output Btn_Repeat
  );

endinterface

// File: rtl/btn_debounce_pulse_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM, registered level/pulse/repeat.
// Auto-repeat timing is built only when BTN_AUTO_REPEAT_EN is defined.
module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd500000,
  parameter int unsigned REPEAT_DELAY    = 32'd25000000,
  parameter int unsigned REPEAT_PERIOD   = 32'd5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic pulse,
  output logic rep
);

  localparam int unsigned CNT_W =
    $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 32'd1);

  localparam logic [1:0] S_IDLE         = IDLE;
  localparam logic [1:0] S_WAIT_PRESS   = WAIT_PRESS;
  localparam logic [1:0] S_HELD         = HELD;
  localparam logic [1:0] S_WAIT_RELEASE = WAIT_RELEASE;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic             s1_r, s2_r;
  logic [1:0]       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             level_r, level_s;
  logic             pulse_r, pulse_s;
  logic             rep_r, rep_s;
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 32'd1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 32'd1);
  // Set once the first (long) repeat delay has elapsed in the current hold.
  logic             rep_phase_r, rep_phase_s;
`endif

  // Next-state, counter and output decode for the debounce FSM.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    level_s = level_r;
    pulse_s = 1'b0;
    rep_s   = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
    rep_phase_s = rep_phase_r;
`endif
    case (state_r)
      S_IDLE: begin
        if (s2_r) begin
          state_s = S_WAIT_PRESS;
          cnt_s   = '0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WAIT_PRESS: begin
        if (!s2_r) begin
          state_s = S_IDLE;
        end else if (cnt_r == DB_LAST) begin
          state_s = S_HELD;
          cnt_s   = '0;
          level_s = 1'b1;
          pulse_s = 1'b1;
          rep_s   = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
          rep_phase_s = 1'b0;
`endif
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      S_HELD: begin
        if (!s2_r) begin
          state_s = S_WAIT_RELEASE;
          cnt_s   = '0;
        end else begin
`ifdef BTN_AUTO_REPEAT_EN
          if (cnt_r == (rep_phase_r ? PER_LAST : DLY_LAST)) begin
            rep_s       = 1'b1;
            cnt_s       = '0;
            rep_phase_s = 1'b1;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
`else
          state_s = S_HELD;
`endif
        end
      end
      S_WAIT_RELEASE: begin
        // A bounce back to 1 re-enters HELD without a new press pulse.
        if (s2_r) begin
          state_s = S_HELD;
          cnt_s   = '0;
`ifdef BTN_AUTO_REPEAT_EN
          rep_phase_s = 1'b0;
`endif
        end else if (cnt_r == DB_LAST) begin
          state_s = S_IDLE;
          level_s = 1'b0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = '0;
        level_s = 1'b0;
      end
    endcase
  end

  // Synchroniser, FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r    <= 1'b0;
      s2_r    <= 1'b0;
      state_r <= S_IDLE;
      cnt_r   <= '0;
      level_r <= 1'b0;
      pulse_r <= 1'b0;
      rep_r   <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      rep_phase_r <= 1'b0;
`endif
    end else begin
      s1_r    <= btn_raw;
      s2_r    <= s1_r;
      state_r <= state_s;
      cnt_r   <= cnt_s;
      level_r <= level_s;
      pulse_r <= pulse_s;
      rep_r   <= rep_s;
`ifdef BTN_AUTO_REPEAT_EN
      rep_phase_r <= rep_phase_s;
`endif
    end
  end

  assign level = level_r;
  assign pulse = pulse_r;
  assign rep   = rep_r;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: N_BTN independent debounce channels behind one interface.
// Define BTN_AUTO_REPEAT_EN to enable auto-repeat pulses on Btn_Repeat.
module btn_debounce_pulse
  import btn_debounce_pkg::*;
#(
  parameter int unsigned N_BTN           = 32'd5,
  parameter int unsigned DEBOUNCE_CYCLES = 32'd500000,
  parameter int unsigned REPEAT_DELAY    = 32'd25000000,
  parameter int unsigned REPEAT_PERIOD   = 32'd5000000
) (
  input  logic                  Clk,
  input  logic                  reset,
  btn_debounce_pulse_if.slave   btn
);

  logic [N_BTN-1:0] level_s;
  logic [N_BTN-1:0] pulse_s;
  logic [N_BTN-1:0] rep_s;

  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk     (Clk),
      .reset   (reset),
      .btn_raw (btn.Btn_In[i]),
      .level   (level_s[i]),
      .pulse   (pulse_s[i]),
      .rep     (rep_s[i])
    );
  end

  assign btn.Btn_Level  = level_s;
  assign btn.Btn_Pulse  = pulse_s;
  assign btn.Btn_Repeat = rep_s;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed self-checking bench for btn_debounce_pulse (DEBOUNCE=4, DELAY=8, PERIOD=3).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_btn_debounce_pulse;
  import btn_debounce_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  btn_debounce_pulse_if #(.N_BTN(32'd5)) bif ();

  btn_debounce_pulse #(
    .N_BTN           (32'd5),
    .DEBOUNCE_CYCLES (32'd4),
    .REPEAT_DELAY    (32'd8),
    .REPEAT_PERIOD   (32'd3)
  ) dut (
    .Clk   (clk),
    .reset (reset),
    .btn   (bif)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [4:0] lvl, input logic [4:0] pls);
    check_value({tag, ".level"}, 32'(bif.Btn_Level), 32'(lvl));
    check_value({tag, ".pulse"}, 32'(bif.Btn_Pulse), 32'(pls));
  endtask

  // Expected Btn_Repeat in visible cycle i when the press pulse is visible in cycle p.
  function automatic logic [4:0] rep_exp(input int i, input int p, input logic [4:0] mask);
`ifdef BTN_AUTO_REPEAT_EN
    if (i == p || (i >= p + 8 && ((i - p - 8) % 3) == 0)) return mask;
`else
    if (i == p) return mask;
`endif
    return 5'b00000;
  endfunction

  initial begin
    logic [3:0] bounce;
    bounce = 4'b1010;
    reset = 1'b1;
    bif.Btn_In = 5'b00000;
    for (int i = 0; i < 3; i++) cyc();
    check_outs("reset", 5'b00000, 5'b00000);
    check_value("reset.rep", 32'(bif.Btn_Repeat), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cyc();

    // 1: single press on C, pulse 6 edges after the first sampling edge
    bif.Btn_In = 5'b00001;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      check_outs("t1", (i >= 7) ? 5'b00001 : 5'b00000, (i == 7) ? 5'b00001 : 5'b00000);
      check_value("t1.rep", 32'(bif.Btn_Repeat), 32'(rep_exp(i, 7, 5'b00001)));
    end
    bif.Btn_In = 5'b00000;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      check_outs("t1rel", (i < 7) ? 5'b00001 : 5'b00000, 5'b00000);
`ifndef BTN_AUTO_REPEAT_EN
      check_value("t1rel.rep", 32'(bif.Btn_Repeat), 32'd0);
`endif
    end

    // 2: 3-cycle glitch on U is rejected
    bif.Btn_In = 5'b00100;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      check_outs("t2hi", 5'b00000, 5'b00000);
      check_value("t2hi.rep", 32'(bif.Btn_Repeat), 32'd0);
    end
    bif.Btn_In = 5'b00000;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      check_outs("t2lo", 5'b00000, 5'b00000);
      check_value("t2lo.rep", 32'(bif.Btn_Repeat), 32'd0);
    end

    // 3: press, then release bounce 0,1,0,1, then stable 0
    bif.Btn_In = 5'b00001;
    for (int i = 1; i <= 9; i++) begin
      cyc();
      check_outs("t3", (i >= 7) ? 5'b00001 : 5'b00000, (i == 7) ? 5'b00001 : 5'b00000);
      check_value("t3.rep", 32'(bif.Btn_Repeat), 32'(rep_exp(i, 7, 5'b00001)));
    end
    for (int j = 0; j < 4; j++) begin
      bif.Btn_In = {4'b0000, bounce[j]};
      cyc();
      check_outs("t3bnc", 5'b00001, 5'b00000);
      check_value("t3bnc.rep", 32'(bif.Btn_Repeat), 32'd0);
    end
    bif.Btn_In = 5'b00000;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      check_outs("t3rel", (i < 7) ? 5'b00001 : 5'b00000, 5'b00000);
      check_value("t3rel.rep", 32'(bif.Btn_Repeat), 32'd0);
    end

    // 4: D held 30 cycles, repeat pattern
    bif.Btn_In = 5'b00010;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      check_outs("t4", (i >= 7) ? 5'b00010 : 5'b00000, (i == 7) ? 5'b00010 : 5'b00000);
      check_value("t4.rep", 32'(bif.Btn_Repeat), 32'(rep_exp(i, 7, 5'b00010)));
    end
    bif.Btn_In = 5'b00000;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      check_outs("t4rel", (i < 7) ? 5'b00010 : 5'b00000, 5'b00000);
`ifndef BTN_AUTO_REPEAT_EN
      check_value("t4rel.rep", 32'(bif.Btn_Repeat), 32'd0);
`endif
    end

    // 5: reset while in WAIT_PRESS with cnt=2, input kept high
    bif.Btn_In = 5'b00001;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      check_outs("t5pre", 5'b00000, 5'b00000);
    end
    reset = 1'b1;
    cyc();
    check_outs("t5rst", 5'b00000, 5'b00000);
    check_value("t5rst.rep", 32'(bif.Btn_Repeat), 32'd0);
    reset = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      check_outs("t5", (i >= 7) ? 5'b00001 : 5'b00000, (i == 7) ? 5'b00001 : 5'b00000);
      check_value("t5.rep", 32'(bif.Btn_Repeat), 32'(rep_exp(i, 7, 5'b00001)));
    end
    // reset while held clears the level, nothing follows after release
    reset = 1'b1;
    bif.Btn_In = 5'b00000;
    cyc();
    check_outs("t5hrst", 5'b00000, 5'b00000);
    check_value("t5hrst.rep", 32'(bif.Btn_Repeat), 32'd0);
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      check_outs("t5post", 5'b00000, 5'b00000);
      check_value("t5post.rep", 32'(bif.Btn_Repeat), 32'd0);
    end

    // 6: C and L pressed in the same cycle
    bif.Btn_In = 5'b10001;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      check_outs("t6", (i >= 7) ? 5'b10001 : 5'b00000, (i == 7) ? 5'b10001 : 5'b00000);
      check_value("t6.rep", 32'(bif.Btn_Repeat), 32'(rep_exp(i, 7, 5'b10001)));
    end
    bif.Btn_In = 5'b00000;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      check_outs("t6rel", (i < 7) ? 5'b10001 : 5'b00000, 5'b00000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
